hazard_unit: RTL and testbench
==============================

// Module: hazard_unit
// PURPOSE
//  Pipeline hazard/forwarding controller for the 5-stage RV32I core. Directly downstream of the ID-stage control unit.
//  Consumes its rs1use/rs2use/hazard_optype/Branch outputs plus ID register indices.
//  Tracks the writers in flight in EXE and MEM with internal shadow registers.
//  Drives PC/IF-ID enables, IF-ID and ID-EXE flushes, and operand/store-data forward selects.
// PARAMETERS
//  REG_ADDR_W  5   register index width
//  PERF_CNT_W  32  perf counter width (HAZARD_PERF_EN only)
// PORTS
//  clk              in   1   core clock, all state on posedge
//  rst              in   1   synchronous, active-high reset
//  rs1use_ID        in   1   ID instruction reads rs1
//  rs2use_ID        in   1   ID instruction reads rs2
//  hazard_optype_ID in   2   00 none, 01 ALU/LUI/AUIPC/JAL(R) write, 10 load, 11 store
//  rd_ID            in   5   ID destination index
//  rs1_ID, rs2_ID   in   5   ID source indices
//  Branch_ID        in   1   branch/jump taken, resolved in ID
//  pc_en            out  1   PC register write enable
//  fd_en            out  1   IF/ID register enable
//  fd_flush         out  1   IF/ID register flush (insert NOP)
//  de_flush         out  1   ID/EXE register flush (insert bubble)
//  forward_a        out  2   rs1 source: 00 RF, 01 EXE ALU, 10 MEM ALU, 11 MEM load data
//  forward_b        out  2   rs2 source, same encoding
//  forward_ls       out  1   store in MEM takes WB load data as store data
// BEHAVIOUR
//  - State: {rd,optype}_EXE, {rd,optype}_MEM, ls_EXE, ls_MEM; all cleared by rst.
//  - Outputs are combinational from ID inputs and state.
//  - While rst=1, outputs are forced: pc_en=1, fd_en=1, flushes=0, forwards=0.
//  - Match rule: rsX matches a stage iff rsXuse_ID=1, rsX_ID==rd_stage, rd_stage!=0, optype_stage in {01,10}.
//  - stall = EXE optype 10 and (rs1 match, or rs2 match with optype_ID!=11).
//    Store data dependent on a load is not a stall.
//  - stall -> pc_en=0, fd_en=0, de_flush=1, fd_flush=0. Stall overrides Branch_ID.
//  - No stall -> pc_en=1, fd_en=1, de_flush=0, fd_flush=Branch_ID.
//  - forward_X priority is EXE first: EXE 01 -> 01; else MEM 01 -> 10; else MEM 10 -> 11; else 00.
//    On stall, forward_X = 00.
//  - Store rs2 vs EXE load: forward_b=00, ls_next=1.
//  - Clock update (rst=0):
//    - {rd,optype}_EXE <= stall ? 0 : ID values.
//    - {rd,optype}_MEM <= EXE values.
//    - ls_EXE <= stall ? 0 : ls_next.
//    - ls_MEM <= ls_EXE.
//    - forward_ls = ls_MEM.
//  - Latency: load-use is exactly 1 stall cycle; no multi-cycle stalls exist.
//  - Store optype 11 and none 00 never match (no rd write).
//  - rst mid-stall: stall drops at once and the shadow load is cleared.
// CONFIGURATION
//  HAZARD_PERF_EN defined:
//   - adds outputs stall_cnt and flush_cnt [PERF_CNT_W-1:0].
//   - stall_cnt increments on each stall cycle; flush_cnt on each fd_flush cycle.
//   - both wrap at 2^PERF_CNT_W and are cleared by rst.
//  Undefined: no counter ports or logic; all other behaviour is identical.
// TESTING
//  1 add x1 in EXE (optype 01, rd 1); ID add rs1=1 -> forward_a=01, no stall.
//  2 lw x1 in EXE; ID add x3,x1,x2 -> 1 cycle pc_en=0/fd_en=0/de_flush=1; next cycle forward_a=11.
//  3 lw x1 then sw x1,0(x2) -> no stall, forward_b=00; forward_ls=1 two cycles later for one cycle.
//  4 ID beq, Branch_ID=1, no deps -> fd_flush=1, pc_en=1, de_flush=0.
//  5 lw x1; beq x1,x0 with Branch_ID=1 -> cycle 1: stall, fd_flush=0; cycle 2: forward_a=11, fd_flush=1.
//  6 rd=x0 writer in EXE with rs1_ID=0 -> forward_a=00.
//    rst during stall -> pc_en=1 that cycle and no stall after.
//    With HAZARD_PERF_EN: counters read 1/1 after scenario 5.

Source files
------------

// File: rtl/hazard_unit.sv
// Load-use stall, branch flush and operand forwarding control for the 5-stage RV32I pipeline.
// Optional stall/flush performance counters are enabled by defining HAZARD_PERF_EN.
module hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rs1use_ID,
  input  logic                  rs2use_ID,
  input  logic [1:0]            hazard_optype_ID,
  input  logic [REG_ADDR_W-1:0] rd_ID,
  input  logic [REG_ADDR_W-1:0] rs1_ID,
  input  logic [REG_ADDR_W-1:0] rs2_ID,
  input  logic                  Branch_ID,
  output logic                  pc_en,
  output logic                  fd_en,
  output logic                  fd_flush,
  output logic                  de_flush,
  output logic [1:0]            forward_a,
  output logic [1:0]            forward_b,
  output logic                  forward_ls
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] stall_cnt,
  output logic [PERF_CNT_W-1:0] flush_cnt
`endif
);

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_ALU   = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  logic [REG_ADDR_W-1:0] r_rdExe;
  logic [REG_ADDR_W-1:0] r_rdMem;
  logic [1:0]            r_optypeExe;
  logic [1:0]            r_optypeMem;
  logic                  r_lsExe;
  logic                  r_lsMem;

  logic w_writesExe;
  logic w_writesMem;
  logic w_rs1MatchExe;
  logic w_rs2MatchExe;
  logic w_rs1MatchMem;
  logic w_rs2MatchMem;
  logic w_stall;
  logic w_lsNext;

  // Only stages that actually write a nonzero register can supply a forwarded value.
  assign w_writesExe = ((r_optypeExe == OP_ALU) || (r_optypeExe == OP_LOAD)) && (r_rdExe != '0);
  assign w_writesMem = ((r_optypeMem == OP_ALU) || (r_optypeMem == OP_LOAD)) && (r_rdMem != '0);

  assign w_rs1MatchExe = rs1use_ID && (rs1_ID == r_rdExe) && w_writesExe;
  assign w_rs2MatchExe = rs2use_ID && (rs2_ID == r_rdExe) && w_writesExe;
  assign w_rs1MatchMem = rs1use_ID && (rs1_ID == r_rdMem) && w_writesMem;
  assign w_rs2MatchMem = rs2use_ID && (rs2_ID == r_rdMem) && w_writesMem;

  // A store whose data comes from the load ahead of it picks the data up in MEM instead of stalling.
  assign w_stall  = !rst && (r_optypeExe == OP_LOAD) &&
                    (w_rs1MatchExe || (w_rs2MatchExe && (hazard_optype_ID != OP_STORE)));
  assign w_lsNext = (r_optypeExe == OP_LOAD) && w_rs2MatchExe && (hazard_optype_ID == OP_STORE);

  function automatic logic [1:0] fwdSel(input logic mExe, input logic mMem,
                                        input logic [1:0] opExe, input logic [1:0] opMem);
    if (mExe)      return (opExe == OP_ALU) ? 2'b01 : 2'b00;
    else if (mMem) return (opMem == OP_ALU) ? 2'b10 : 2'b11;
    else           return 2'b00;
  endfunction

  always_comb begin
    pc_en      = 1'b1;
    fd_en      = 1'b1;
    fd_flush   = 1'b0;
    de_flush   = 1'b0;
    forward_a  = 2'b00;
    forward_b  = 2'b00;
    forward_ls = 1'b0;
    if (!rst) begin
      forward_ls = r_lsMem;
      if (w_stall) begin
        pc_en    = 1'b0;
        fd_en    = 1'b0;
        de_flush = 1'b1;
      end else begin
        fd_flush  = Branch_ID;
        forward_a = fwdSel(w_rs1MatchExe, w_rs1MatchMem, r_optypeExe, r_optypeMem);
        forward_b = fwdSel(w_rs2MatchExe, w_rs2MatchMem, r_optypeExe, r_optypeMem);
      end
    end
  end

  // A stall turns the instruction entering EXE into a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdExe     <= '0;
      r_optypeExe <= OP_NONE;
      r_rdMem     <= '0;
      r_optypeMem <= OP_NONE;
      r_lsExe     <= 1'b0;
      r_lsMem     <= 1'b0;
    end else begin
      r_rdExe     <= w_stall ? '0 : rd_ID;
      r_optypeExe <= w_stall ? OP_NONE : hazard_optype_ID;
      r_rdMem     <= r_rdExe;
      r_optypeMem <= r_optypeExe;
      r_lsExe     <= w_stall ? 1'b0 : w_lsNext;
      r_lsMem     <= r_lsExe;
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_CNT_W-1:0] r_stallCnt;
  logic [PERF_CNT_W-1:0] r_flushCnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stallCnt <= '0;
      r_flushCnt <= '0;
    end else begin
      if (w_stall)  r_stallCnt <= r_stallCnt + 1'b1;
      if (fd_flush) r_flushCnt <= r_flushCnt + 1'b1;
    end
  end

  assign stall_cnt = r_stallCnt;
  assign flush_cnt = r_flushCnt;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed ID-stage vectors push expected control outputs,
// and a monitor pops and compares them every cycle.
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic       rs1use_ID;
  logic       rs2use_ID;
  logic [1:0] hazard_optype_ID;
  logic [4:0] rd_ID;
  logic [4:0] rs1_ID;
  logic [4:0] rs2_ID;
  logic       Branch_ID;
  logic       pc_en;
  logic       fd_en;
  logic       fd_flush;
  logic       de_flush;
  logic [1:0] forward_a;
  logic [1:0] forward_b;
  logic       forward_ls;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] flush_cnt;
`endif

  int testsRun;
  int testsFailed;

  logic [8:0] expQ[$];
  string      nameQ[$];

  hazard_unit #(.REG_ADDR_W(5), .PERF_CNT_W(32)) dut (
    .clk(clk),
    .rst(rst),
    .rs1use_ID(rs1use_ID),
    .rs2use_ID(rs2use_ID),
    .hazard_optype_ID(hazard_optype_ID),
    .rd_ID(rd_ID),
    .rs1_ID(rs1_ID),
    .rs2_ID(rs2_ID),
    .Branch_ID(Branch_ID),
    .pc_en(pc_en),
    .fd_en(fd_en),
    .fd_flush(fd_flush),
    .de_flush(de_flush),
    .forward_a(forward_a),
    .forward_b(forward_b),
    .forward_ls(forward_ls)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected vector layout: {pc_en, fd_en, fd_flush, de_flush, forward_a, forward_b, forward_ls}
  function automatic logic [8:0] mkExp(input logic pc, input logic fd, input logic ff, input logic df,
                                       input logic [1:0] fa, input logic [1:0] fb, input logic fl);
    return {pc, fd, ff, df, fa, fb, fl};
  endfunction

  // Drives one ID-stage vector shortly after the clock edge and queues its expected response.
  task automatic applyStimulus(input string name, input logic rstIn, input logic r1u, input logic r2u,
                               input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic br, input logic [8:0] expVec);
    @(posedge clk);
    #1;
    rst              = rstIn;
    rs1use_ID        = r1u;
    rs2use_ID        = r2u;
    hazard_optype_ID = op;
    rd_ID            = rd;
    rs1_ID           = rs1;
    rs2_ID           = rs2;
    Branch_ID        = br;
    expQ.push_back(expVec);
    nameQ.push_back(name);
  endtask

  task automatic checkOutput(input string name, input logic [8:0] actual, input logic [8:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %b, expected %b", name, actual, expected);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (expQ.size() != 0) begin
        logic [8:0] e;
        string      n;
        e = expQ.pop_front();
        n = nameQ.pop_front();
        checkOutput(n, {pc_en, fd_en, fd_flush, de_flush, forward_a, forward_b, forward_ls}, e);
      end
    end
  end

  initial begin
    logic [8:0] nrm;
    testsRun    = 0;
    testsFailed = 0;
    rst = 1'b1; rs1use_ID = 1'b0; rs2use_ID = 1'b0; hazard_optype_ID = 2'b00;
    rd_ID = '0; rs1_ID = '0; rs2_ID = '0; Branch_ID = 1'b0;
    nrm = mkExp(1, 1, 0, 0, 2'b00, 2'b00, 0);

    applyStimulus("reset_forced",   1, 1, 1, 2'b01, 5'd3, 5'd1, 5'd2, 1, nrm);
    applyStimulus("reset_idle",     1, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, nrm);
    // Scenario 1 plus MEM-stage forwarding
    applyStimulus("addi_x1",        0, 0, 0, 2'b01, 5'd1, 5'd0, 5'd0, 0, nrm);
    applyStimulus("exe_alu_fwd",    0, 1, 1, 2'b01, 5'd5, 5'd1, 5'd2, 0, mkExp(1, 1, 0, 0, 2'b01, 2'b00, 0));
    applyStimulus("mem_exe_fwd",    0, 1, 1, 2'b01, 5'd6, 5'd1, 5'd5, 0, mkExp(1, 1, 0, 0, 2'b10, 2'b01, 0));
    // Scenario 6: x0 writer never forwards
    applyStimulus("write_x0",       0, 0, 0, 2'b01, 5'd0, 5'd0, 5'd0, 0, nrm);
    applyStimulus("x0_no_fwd",      0, 1, 1, 2'b01, 5'd7, 5'd0, 5'd6, 0, mkExp(1, 1, 0, 0, 2'b00, 2'b10, 0));
    // Scenario 2: load-use
    applyStimulus("lw_x1_a",        0, 1, 0, 2'b10, 5'd1, 5'd2, 5'd0, 0, nrm);
    applyStimulus("load_use_stall", 0, 1, 1, 2'b01, 5'd3, 5'd1, 5'd2, 0, mkExp(0, 0, 0, 1, 2'b00, 2'b00, 0));
    applyStimulus("load_use_fwd",   0, 1, 1, 2'b01, 5'd3, 5'd1, 5'd2, 0, mkExp(1, 1, 0, 0, 2'b11, 2'b00, 0));
    // Scenario 3: store data from preceding load
    applyStimulus("lw_x1_b",        0, 1, 0, 2'b10, 5'd1, 5'd2, 5'd0, 0, nrm);
    applyStimulus("sw_no_stall",    0, 1, 1, 2'b11, 5'd0, 5'd2, 5'd1, 0, nrm);
    applyStimulus("ls_not_yet",     0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, nrm);
    applyStimulus("ls_active",      0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, mkExp(1, 1, 0, 0, 2'b00, 2'b00, 1));
    applyStimulus("ls_done",        0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, nrm);
    // Scenario 4: plain taken branch
    applyStimulus("branch_flush",   0, 1, 1, 2'b00, 5'd0, 5'd5, 5'd6, 1, mkExp(1, 1, 1, 0, 2'b00, 2'b00, 0));
    // Reset arriving while a load-use stall would be asserted
    applyStimulus("lw_x1_c",        0, 1, 0, 2'b10, 5'd1, 5'd2, 5'd0, 0, nrm);
    applyStimulus("rst_mid_stall",  1, 1, 1, 2'b01, 5'd3, 5'd1, 5'd2, 0, nrm);
    applyStimulus("after_rst",      0, 1, 1, 2'b01, 5'd3, 5'd1, 5'd2, 0, nrm);
    // Scenario 5: load-use on a taken branch
    applyStimulus("lw_x1_d",        0, 1, 0, 2'b10, 5'd1, 5'd2, 5'd0, 0, nrm);
    applyStimulus("br_stall",       0, 1, 1, 2'b00, 5'd0, 5'd1, 5'd0, 1, mkExp(0, 0, 0, 1, 2'b00, 2'b00, 0));
    applyStimulus("br_fwd_flush",   0, 1, 1, 2'b00, 5'd0, 5'd1, 5'd0, 1, mkExp(1, 1, 1, 0, 2'b11, 2'b00, 0));
    applyStimulus("tail_nop",       0, 0, 0, 2'b00, 5'd0, 5'd0, 5'd0, 0, nrm);

    for (int i = 0; i < 20 && expQ.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    testsRun++;
    if (expQ.size() != 0) begin
      testsFailed++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
    end

`ifdef HAZARD_PERF_EN
    testsRun++;
    if (stall_cnt !== 32'd1) begin
      testsFailed++;
      $display("[TB] FAIL stall_cnt: got %0d, expected 1", stall_cnt);
    end
    testsRun++;
    if (flush_cnt !== 32'd1) begin
      testsFailed++;
      $display("[TB] FAIL flush_cnt: got %0d, expected 1", flush_cnt);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
